vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen_if.sv | 31 +++
 rtl/vga_sync_gen.sv | 102 ++++++++++
 tb/tb_vga_sync_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Scan position and sync strobes from vga_sync_gen.
// master drives, slave (vga_controller, connector) consumes.
interface vga_sync_gen_if;
  logic [9:0] CounterX;
  logic [9:0] CounterY;
  logic       inDisplayArea;
  logic       vga_h_sync;
  logic       vga_v_sync;
  logic       display_en;
  logic       frame_tick;

  modport master (
    output CounterX,
    output CounterY,
    output inDisplayArea,
    output vga_h_sync,
    output vga_v_sync,
    output display_en,
    output frame_tick
  );

  modport slave (
    input CounterX,
    input CounterY,
    input inDisplayArea,
    input vga_h_sync,
    input vga_v_sync,
    input display_en,
    input frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA scan counters, sync decode and delayed strobes.
// Sync/enable delayed to line up with registered pixel data.
module vga_sync_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic          clk,
  input  logic          reset,
  vga_sync_gen_if.master vga
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] nx;
  logic [9:0] ny;
  logic       ide;
  logic       ft;
  logic       hs0;
  logic       vs0;

  always_comb begin
    nx = x + 10'd1;
    ny = y;
    if (x == H_LAST) begin
      nx = '0;
      ny = (y == V_LAST) ? '0 : y + 10'd1;
    end
  end

  // Decode from next-state so flags match the counters they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      x   <= '0;
      y   <= '0;
      ide <= 1'b1;
      ft  <= 1'b0;
      hs0 <= 1'b1;
      vs0 <= 1'b1;
    end else begin
      x   <= nx;
      y   <= ny;
      ide <= (nx < H_ACT) && (ny < V_ACT);
      ft  <= (nx == '0) && (ny == V_ACT);
      hs0 <= !((nx >= HS_BEG) && (nx <= HS_END));
      vs0 <= !((ny >= VS_BEG) && (ny <= VS_END));
    end
  end

  assign vga.CounterX      = x;
  assign vga.CounterY      = y;
  assign vga.inDisplayArea = ide;
  assign vga.frame_tick    = ft;

  if (SYNC_DELAY == 0) begin : g_nodly
    assign vga.vga_h_sync = hs0;
    assign vga.vga_v_sync = vs0;
    assign vga.display_en = ide;
  end else begin : g_dly
    logic [SYNC_DELAY-1:0] hs_d;
    logic [SYNC_DELAY-1:0] vs_d;
    logic [SYNC_DELAY-1:0] de_d;

    always_ff @(posedge clk) begin
      if (reset) begin
        hs_d <= '1;
        vs_d <= '1;
        de_d <= '0;
      end else begin
        hs_d[0] <= hs0;
        vs_d[0] <= vs0;
        de_d[0] <= ide;
        for (int i = 1; i < SYNC_DELAY; i++) begin
          hs_d[i] <= hs_d[i-1];
          vs_d[i] <= vs_d[i-1];
          de_d[i] <= de_d[i-1];
        end
      end
    end

    assign vga.vga_h_sync = hs_d[SYNC_DELAY-1];
    assign vga.vga_v_sync = vs_d[SYNC_DELAY-1];
    assign vga.display_en = de_d[SYNC_DELAY-1];
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: cycle-count reference model,
// random resets, default and shrunken timings.
module tb_vga_sync_gen;
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVA = 12, SVF = 3, SVS = 2, SVB = 4;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int S_FRAME = SHT * (SVA + SVF + SVS + SVB);

  logic clk;
  logic reset;
  int   n;
  int   checks;
  int   errors;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       ide;
    logic       hs;
    logic       vs;
    logic       de;
    logic       ft;
  } exp_t;

  vga_sync_gen_if big_if ();
  vga_sync_gen_if s0_if ();
  vga_sync_gen_if s1_if ();
  vga_sync_gen_if s3_if ();

  vga_sync_gen #(.SYNC_DELAY(1)) u_big (
    .clk(clk), .reset(reset), .vga(big_if.master)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_DELAY(0)
  ) u_s0 (
    .clk(clk), .reset(reset), .vga(s0_if.master)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_DELAY(1)
  ) u_s1 (
    .clk(clk), .reset(reset), .vga(s1_if.master)
  );

  vga_sync_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_DELAY(3)
  ) u_s3 (
    .clk(clk), .reset(reset), .vga(s3_if.master)
  );

  exp_t big_obs, s0_obs, s1_obs, s3_obs;

  assign big_obs = {big_if.CounterX, big_if.CounterY,
    big_if.inDisplayArea, big_if.vga_h_sync,
    big_if.vga_v_sync, big_if.display_en, big_if.frame_tick};
  assign s0_obs = {s0_if.CounterX, s0_if.CounterY,
    s0_if.inDisplayArea, s0_if.vga_h_sync,
    s0_if.vga_v_sync, s0_if.display_en, s0_if.frame_tick};
  assign s1_obs = {s1_if.CounterX, s1_if.CounterY,
    s1_if.inDisplayArea, s1_if.vga_h_sync,
    s1_if.vga_v_sync, s1_if.display_en, s1_if.frame_tick};
  assign s3_obs = {s3_if.CounterX, s3_if.CounterY,
    s3_if.inDisplayArea, s3_if.vga_h_sync,
    s3_if.vga_v_sync, s3_if.display_en, s3_if.frame_tick};

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got=%h expected=%h",
               tag, n, got, exp);
    end
  endtask

  // Expected outputs n edges after the last reset edge.
  function automatic exp_t model(
    input int cnt, input int d,
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb);
    exp_t e;
    int ht, fr, p, px, py, q, qx, qy;
    ht = ha + hf + hs + hb;
    fr = ht * (va + vf + vs + vb);
    p  = cnt % fr;
    px = p % ht;
    py = p / ht;
    e.x   = 10'(px);
    e.y   = 10'(py);
    e.ide = (px < ha) && (py < va);
    e.ft  = (px == 0) && (py == va);
    if (cnt >= d) begin
      q  = (cnt - d) % fr;
      qx = q % ht;
      qy = q / ht;
      e.hs = !((qx >= ha + hf) && (qx < ha + hf + hs));
      e.vs = !((qy >= va + vf) && (qy < va + vf + vs));
      e.de = (qx < ha) && (qy < va);
    end else begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.de = 1'b0;
    end
    return e;
  endfunction

  int  last_tick;
  bit  tick_ok;
  int  vs_run;
  bit  vs_ok;
  int  hs_run;
  bit  hs_ok;

  task automatic step();
    bit r;
    r = reset;
    @(posedge clk);
    if (r) n = 0;
    else   n++;
    #1;
    chk("big", 32'(big_obs),
        32'(model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33)));
    chk("small_d0", 32'(s0_obs),
        32'(model(n, 0, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)));
    chk("small_d1", 32'(s1_obs),
        32'(model(n, 1, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)));
    chk("small_d3", 32'(s3_obs),
        32'(model(n, 3, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB)));
    if (r) begin
      tick_ok = 0;
      vs_run = 0;
      vs_ok = 0;
      hs_run = 0;
      hs_ok = 0;
    end
    if (s0_if.frame_tick) begin
      if (tick_ok) chk("tick_period", n - last_tick, S_FRAME);
      last_tick = n;
      tick_ok = 1;
    end
    if (!s1_if.vga_v_sync) vs_run++;
    else begin
      if (vs_ok && vs_run > 0) chk("vsync_width", vs_run, SVS * SHT);
      vs_run = 0;
      vs_ok = !r;
    end
    if (!big_if.vga_h_sync) hs_run++;
    else begin
      if (hs_ok && hs_run > 0) chk("hsync_width", hs_run, 96);
      hs_run = 0;
      hs_ok = !r;
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    int cnt;
    bit hit;
    clk = 0;
    reset = 1;
    n = 0;
    checks = 0;
    errors = 0;
    tick_ok = 0;
    last_tick = 0;
    vs_run = 0;
    vs_ok = 0;
    hs_run = 0;
    hs_ok = 0;

    run(3);
    chk("reset_vals", 32'(big_obs), {7'd0, 10'd0, 10'd0, 5'b11100});
    reset = 0;
    step();
    chk("first_x", 32'(big_if.CounterX), 1);

    run(10000);
    chk("row_reached", 32'(big_if.CounterY), 12);

    reset = 1;
    run(3);
    reset = 0;
    step();
    chk("first_x_again", 32'(big_if.CounterX), 1);

    for (int it = 0; it < 25; it++) begin
      run($urandom_range(50, 1500));
      if ($urandom_range(0, 2) == 0) begin
        reset = 1;
        run($urandom_range(1, 4));
        reset = 0;
      end
    end
    run(1500);

    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      hit = !s1_if.vga_v_sync && !s1_if.vga_h_sync;
    end
    chk("midsync_reach", 32'(hit), 1);
    reset = 1;
    step();
    chk("midsync_sync", {s1_if.vga_h_sync, s1_if.vga_v_sync}, 2'b11);
    chk("midsync_pos", {s1_if.CounterX, s1_if.CounterY}, 0);
    reset = 0;
    cnt = 0;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      cnt++;
      hit = s0_if.frame_tick;
    end
    chk("tick_after_reset", cnt, SVA * SHT);
    run(50);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
